// File: rtl/dmem_pkg.sv
// Shared defaults and the store-buffer entry type for the data-memory unit.
package dmem_pkg;
    localparam int ADDR_W_DEF   = 8;
    localparam int SB_DEPTH_DEF = 2;
    // Word index is stored at full width so any ADDR_W up to 30 fits one entry type.
    localparam int IDX_MAX      = 30;

    typedef struct packed {
        logic [IDX_MAX-1:0] index;
        logic [31:0]        data;
    } sbEntry_t;
endpackage

// File: rtl/dmem_sb_fifo.sv
// Store-buffer FIFO: entry storage, wrapping pointers and occupancy count.
module dmem_sb_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq,
    input  sbEntry_t                   enqEntry,
    input  logic                       deq,
    output sbEntry_t [DEPTH-1:0]       entries,
    output logic [$clog2(DEPTH)-1:0]   rdPtr,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wrPtr;
    sbEntry_t [DEPTH-1:0] mem;

    assign entries = mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (enq) wrPtr <= wrPtr + PW'(1);
            if (deq) rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // Payload needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (enq) mem[wrPtr] <= enqEntry;
    end
endmodule

// File: rtl/dmem_unit.sv
// Data-memory unit: single-port RAM fronted by an in-order store buffer.
// Define DMEM_FWD_EN to forward buffered stores to loads instead of stalling.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 ALUOutM,
    input  logic [31:0]                 WriteDataM,
    input  logic                        MemWriteM,
    input  logic                        MemReadM,
    output logic [31:0]                 DmmRD,
    output logic                        StallM,
    output logic                        MisalignM,
    output logic [$clog2(SB_DEPTH):0]   SbCount
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0] ram [2**ADDR_W];

    sbEntry_t [SB_DEPTH-1:0] entries;
    sbEntry_t                head;
    logic [PW-1:0]           rdPtr;
    logic [ADDR_W-1:0]       idx;
    logic aligned, isStore, isLoad, full, hit, loadGo, enq, drain;
    logic [31:0] fwdData;
    logic unusedAddrBits;

    assign idx            = ALUOutM[ADDR_W+1:2];
    assign unusedAddrBits = ^ALUOutM[31:ADDR_W+2];
    assign aligned        = (ALUOutM[1:0] == 2'b00);
    assign MisalignM      = (MemReadM | MemWriteM) & ~aligned;
    // A simultaneous read+write request is a store only.
    assign isStore        = MemWriteM & aligned;
    assign isLoad         = MemReadM & ~MemWriteM & aligned;
    assign full           = (SbCount == CW'(SB_DEPTH));

    // Youngest live entry with a matching index wins.
    always_comb begin
        logic [PW-1:0] slot;
        hit     = 1'b0;
        fwdData = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot = rdPtr + PW'(i);
            if ((CW'(i) < SbCount) && (entries[slot].index == IDX_MAX'(idx))) begin
                hit     = 1'b1;
                fwdData = entries[slot].data;
            end
        end
    end

`ifdef DMEM_FWD_EN
    assign StallM = (isLoad | isStore) & full;
    assign DmmRD  = loadGo ? (hit ? fwdData : ram[idx]) : 32'h0;
`else
    // Without forwarding a load waits until the buffer holds nothing for its word.
    logic [31:0] unusedFwd;
    assign unusedFwd = fwdData;
    assign StallM = ((isLoad | isStore) & full) | (isLoad & hit);
    assign DmmRD  = loadGo ? ram[idx] : 32'h0;
`endif

    assign loadGo = isLoad & ~StallM;
    assign enq    = isStore & ~StallM;
    // The RAM port serves the load when one proceeds, otherwise the oldest store.
    assign drain  = (SbCount != '0) & ~loadGo;
    assign head   = entries[rdPtr];

    always_ff @(posedge clk) begin
        if (drain) ram[head.index[ADDR_W-1:0]] <= head.data;
    end

    dmem_sb_fifo #(.DEPTH(SB_DEPTH)) uSbFifo (
        .clk      (clk),
        .reset    (reset),
        .enq      (enq),
        .enqEntry ('{index: IDX_MAX'(idx), data: WriteDataM}),
        .deq      (drain),
        .entries  (entries),
        .rdPtr    (rdPtr),
        .count    (SbCount)
    );
endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: directed vector table, corner sequences, random vs queue model.
module tb_dmem_unit;
    localparam int SB_DEPTH = 2;
    localparam int NWORDS   = 256;

    logic        clk = 0;
    logic        reset = 0;
    logic [31:0] ALUOutM = 0, WriteDataM = 0;
    logic        MemWriteM = 0, MemReadM = 0;
    logic [31:0] DmmRD;
    logic        StallM, MisalignM;
    logic [1:0]  SbCount;

    dmem_unit #(.ADDR_W(8), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .reset(reset), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .MemWriteM(MemWriteM), .MemReadM(MemReadM), .DmmRD(DmmRD),
        .StallM(StallM), .MisalignM(MisalignM), .SbCount(SbCount)
    );

    always #5 clk = ~clk;

    int nChecks = 0, nFail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: memory array plus an ordered queue of pending stores.
    typedef struct { int idx; logic [31:0] data; } mEnt_t;
    mEnt_t       mq[$];
    logic [31:0] mmem [NWORDS];
    logic [31:0] eRD;
    logic        eStall, eMis, eLoad, eStore;
    logic [31:0] aRD;
    logic        aStall, aMis;
    int          aCnt;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 | i;
    endfunction

    function automatic void modelEval(input logic rd, wr, input logic [31:0] addr);
        int idx;
        bit ok, hit;
        logic [31:0] v;
        idx    = (addr >> 2) % NWORDS;
        ok     = (addr % 4) == 0;
        eStore = wr && ok;
        eLoad  = rd && !wr && ok;
        eMis   = (rd || wr) && !ok;
        hit    = 0;
        v      = 0;
        foreach (mq[i]) if (mq[i].idx == idx) begin hit = 1; v = mq[i].data; end
        eStall = (eLoad || eStore) && (mq.size() == SB_DEPTH);
`ifndef DMEM_FWD_EN
        if (eLoad && hit) eStall = 1;
`endif
        eRD = (eLoad && !eStall) ? (hit ? v : mmem[idx]) : 32'h0;
    endfunction

    function automatic void modelCommit(input logic [31:0] addr, data);
        mEnt_t e;
        if (mq.size() > 0 && !(eLoad && !eStall)) begin
            mmem[mq[0].idx] = mq[0].data;
            void'(mq.pop_front());
        end
        if (eStore && !eStall) begin
            e.idx = (addr >> 2) % NWORDS;
            e.data = data;
            mq.push_back(e);
        end
    endfunction

    // Called at posedge+1; returns with outputs sampled and the model advanced.
    task automatic drive(input logic rd, wr, input logic [31:0] addr, data);
        MemReadM = rd; MemWriteM = wr; ALUOutM = addr; WriteDataM = data;
        #1;
        aRD = DmmRD; aStall = StallM; aMis = MisalignM;
        modelEval(rd, wr, addr);
        @(posedge clk); #1;
        modelCommit(addr, data);
        aCnt = int'(SbCount);
    endtask

    task automatic driveModelChk(input string name, input logic rd, wr, input logic [31:0] addr, data);
        drive(rd, wr, addr, data);
        chk({name, ".rd"}, aRD, eRD);
        chk({name, ".stall"}, 32'(aStall), 32'(eStall));
        chk({name, ".mis"}, 32'(aMis), 32'(eMis));
        chk({name, ".cnt"}, aCnt, mq.size());
    endtask

    typedef struct {
        string name; logic rd, wr; logic [31:0] addr, data, expRD;
        logic expStall, expMis; int expCnt;
    } vec_t;
    vec_t vt[$];

    function automatic void addV(input string n, input logic rd, wr, input logic [31:0] a, d, r,
                                 input logic s, m, input int c);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.data = d; v.expRD = r;
        v.expStall = s; v.expMis = m; v.expCnt = c;
        vt.push_back(v);
    endfunction

    initial begin
        for (int i = 0; i < NWORDS; i++) mmem[i] = 'x;

        addV("st10",   0, 1, 32'h10,  32'hDEADBEEF, 0, 0, 0, 1);
        addV("idle1",  0, 0, 32'h0,   0, 0, 0, 0, 0);
        addV("idle2",  0, 0, 32'h0,   0, 0, 0, 0, 0);
        addV("ld10",   1, 0, 32'h10,  0, 32'hDEADBEEF, 0, 0, 0);
        addV("st8a",   0, 1, 32'h8,   32'hA, 0, 0, 0, 1);
        addV("st8b",   0, 1, 32'h8,   32'hB, 0, 0, 0, 1);
`ifdef DMEM_FWD_EN
        addV("ld8hit", 1, 0, 32'h8,   0, 32'hB, 0, 0, 1);
`else
        addV("ld8hit", 1, 0, 32'h8,   0, 0, 1, 0, 0);
`endif
        addV("idle3",  0, 0, 32'h0,   0, 0, 0, 0, 0);
        addV("ld8",    1, 0, 32'h8,   0, 32'hB, 0, 0, 0);
        addV("ldmis",  1, 0, 32'h13,  0, 0, 0, 1, 0);
        addV("stmis",  0, 1, 32'h12,  32'h77, 0, 0, 1, 0);
        addV("rdwr20", 1, 1, 32'h20,  32'h11111111, 0, 0, 0, 1);
`ifdef DMEM_FWD_EN
        addV("ld20hit",1, 0, 32'h20,  0, 32'h11111111, 0, 0, 1);
`else
        addV("ld20hit",1, 0, 32'h20,  0, 0, 1, 0, 0);
`endif
        addV("idle4",  0, 0, 32'h0,   0, 0, 0, 0, 0);
        addV("ld20",   1, 0, 32'h20,  0, 32'h11111111, 0, 0, 0);
        addV("ldhiadr",1, 0, 32'h420, 0, 32'h11111111, 0, 0, 0);
        addV("ld44",   1, 0, 32'h44,  0, 32'hC0DE0011, 0, 0, 0);

        // Reset state before any clock edge is released.
        #3;
        chk("rst.rd", DmmRD, 0);
        chk("rst.stall", 32'(StallM), 0);
        chk("rst.mis", 32'(MisalignM), 0);
        chk("rst.cnt", 32'(SbCount), 0);
        #4 reset = 1;
        @(posedge clk); #1;

        // Give every RAM word a known value.
        for (int i = 0; i < NWORDS; i++) drive(0, 1, 32'(i) << 2, pat(i));
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("fill.cnt", 32'(SbCount), 0);

        foreach (vt[i]) begin
            drive(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data);
            chk({vt[i].name, ".rd"}, aRD, vt[i].expRD);
            chk({vt[i].name, ".stall"}, 32'(aStall), 32'(vt[i].expStall));
            chk({vt[i].name, ".mis"}, 32'(aMis), 32'(vt[i].expMis));
            chk({vt[i].name, ".cnt"}, aCnt, vt[i].expCnt);
        end

        // Back-to-back stores then loads to the same words.
        driveModelChk("b2b.st0", 0, 1, 32'h0, 32'h1234);
        driveModelChk("b2b.st4", 0, 1, 32'h4, 32'h5678);
        driveModelChk("b2b.ld4", 1, 0, 32'h4, 0);
        driveModelChk("b2b.ld4b", 1, 0, 32'h4, 0);
        driveModelChk("b2b.ld0", 1, 0, 32'h0, 0);
        driveModelChk("b2b.st8", 0, 1, 32'h8, 32'h9ABC);
        driveModelChk("b2b.idle", 0, 0, 0, 0);

        // Asynchronous reset discards a buffered store.
        driveModelChk("rs.st30", 0, 1, 32'h30, 32'h55AA55AA);
        chk("rs.cntpre", 32'(SbCount), 1);
        MemWriteM = 0; MemReadM = 0;
        reset = 0;
        #1;
        chk("rs.cnt", 32'(SbCount), 0);
        chk("rs.rd", DmmRD, 0);
        chk("rs.stall", 32'(StallM), 0);
        mq.delete();
        #1 reset = 1;
        @(posedge clk); #1;
        drive(1, 0, 32'h30, 0);
        chk("rs.ld30", aRD, pat(12));

        // Random traffic over a handful of words to provoke hits.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a;
            logic rd, wr;
            a  = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            rd = 1'($urandom);
            wr = 1'($urandom);
            driveModelChk("rand", rd, wr, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
